// File: rtl/udma_qspi_cmd_arbiter.sv
// Transaction-atomic two-way arbiter for the QSPI master command channel.
// Round-robin on ties, ownership held until EOT, watchdog injects EOT on a stalled owner.
module udma_qspi_cmd_arbiter #(
    parameter logic [3:0]  EOT_OPCODE     = 4'h9,
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic        sys_clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic [31:0] req0_data_i,
    input  logic        req0_valid_i,
    output logic        req0_ready_o,
    input  logic [31:0] req1_data_i,
    input  logic        req1_valid_i,
    output logic        req1_ready_o,
    output logic [31:0] cmd_data_o,
    output logic        cmd_valid_o,
    input  logic        cmd_ready_i,
    output logic        busy_o,
    output logic        owner_o,
    output logic [1:0]  done_o,
    output logic [1:0]  abort_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_ABORT = 2'd2
    } state_e;

    localparam bit                   LP_WDOG_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_WIDTH-1:0] LP_CNT_LIMIT =
        LP_WDOG_EN ? CNT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

    state_e               r_state;
    logic                 r_owner;
    logic                 r_last;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [1:0]           r_done;
    logic [1:0]           r_abort;

    logic        w_own_valid;
    logic [31:0] w_own_data;
    logic        w_hs;
    logic        w_eot;
    logic        w_pick;

    assign w_own_valid = r_owner ? req1_valid_i : req0_valid_i;
    assign w_own_data  = r_owner ? req1_data_i  : req0_data_i;
    assign w_hs        = (r_state == ST_BUSY) && w_own_valid && cmd_ready_i;
    assign w_eot       = (w_own_data[31:28] == EOT_OPCODE);
    // On a tie the requester that was not served last wins; otherwise the lone requester.
    assign w_pick      = (req0_valid_i && req1_valid_i) ? ~r_last : req1_valid_i;

    always_comb begin
        cmd_valid_o  = 1'b0;
        cmd_data_o   = '0;
        req0_ready_o = 1'b0;
        req1_ready_o = 1'b0;
        case (r_state)
            ST_BUSY: begin
                cmd_valid_o  = w_own_valid;
                cmd_data_o   = w_own_data;
                req0_ready_o = ~r_owner & cmd_ready_i;
                req1_ready_o =  r_owner & cmd_ready_i;
            end
            ST_ABORT: begin
                cmd_valid_o = 1'b1;
                cmd_data_o  = {EOT_OPCODE, 28'h0};
            end
            default: ;
        endcase
    end

    assign busy_o  = (r_state != ST_IDLE);
    assign owner_o = r_owner;
    assign done_o  = r_done;
    assign abort_o = r_abort;

    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
            r_cnt   <= '0;
            r_done  <= '0;
            r_abort <= '0;
        end else begin
            // NOTE: pulses are cleared first each cycle; a later non-blocking write to one bit overrides the clear.
            r_done  <= '0;
            r_abort <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (en_i && (req0_valid_i || req1_valid_i)) begin
                        r_owner <= w_pick;
                        r_cnt   <= '0;
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (w_hs) begin
                        r_cnt <= '0;
                        if (w_eot) begin
                            r_state         <= ST_IDLE;
                            r_done[r_owner] <= 1'b1;
                            r_last          <= r_owner;
                        end
                    end else if (!w_own_valid && LP_WDOG_EN) begin
                        if (r_cnt == LP_CNT_LIMIT) begin
                            r_state <= ST_ABORT;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_ABORT: begin
                    if (cmd_ready_i) begin
                        r_state          <= ST_IDLE;
                        r_abort[r_owner] <= 1'b1;
                        r_last           <= r_owner;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
